// File: rtl/oversample_voter.sv
// Purpose : majority-vote sampler for an oversampled serial bit; samples rx_in over a
//           window centred on the bit middle and votes once the window has passed.
// Latency : sampled_bit/bit_valid/noise_err register one clock after edge_cnt == vote point.
// Backpressure: none; the RX FSM paces the block through samp_en and edge_cnt.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   rx_in        synchronised serial line
//   samp_en      sampling enable from the RX FSM; low aborts the current bit
//   edge_cnt     oversample edge index within the current bit (0..prescale-1)
//   prescale     oversample ratio, static while samp_en is high
//   sampled_bit  registered vote result, held between votes
//   bit_valid    one-cycle pulse when sampled_bit/noise_err were updated
//   noise_err    samples of the last voted bit disagreed, or too few were taken
//   cfg_err      combinational: prescale too small for NUM_SAMPLES
module oversample_voter #(
    parameter int PRESC_W     = 6,
    parameter int NUM_SAMPLES = 3   // 1, 3, 5 or 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_in,
    input  logic               samp_en,
    input  logic [PRESC_W-1:0] edge_cnt,
    input  logic [PRESC_W-1:0] prescale,
    output logic               sampled_bit,
    output logic               bit_valid,
    output logic               noise_err,
    output logic               cfg_err
);

    // Half-width of the sampling window around the centre edge.
    localparam int H   = (NUM_SAMPLES - 1) / 2;
    localparam int HP1 = H + 1;

    localparam logic [PRESC_W:0] H_V   = H[PRESC_W:0];
    localparam logic [PRESC_W:0] HP1_V = HP1[PRESC_W:0];
    localparam logic [PRESC_W:0] ONE_V = {{PRESC_W{1'b0}}, 1'b1};
    localparam logic [2:0]       H_3   = H[2:0];
    localparam logic [2:0]       N_3   = NUM_SAMPLES[2:0];

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    // ------------------------------------------------------------------
    // Window geometry, computed one bit wider than the edge counter so the
    // subtractions for small prescale values stay unambiguous.
    // ------------------------------------------------------------------
    logic [PRESC_W:0] presc_x;
    logic [PRESC_W:0] edge_x;
    logic [PRESC_W:0] half;
    logic [PRESC_W:0] centre;
    logic [PRESC_W:0] win_lo;
    logic [PRESC_W:0] win_hi;
    logic [PRESC_W:0] vote_pt;
    logic [PRESC_W:0] last_pt;

    assign presc_x = {1'b0, prescale};
    assign edge_x  = {1'b0, edge_cnt};
    assign half    = presc_x >> 1;
    assign centre  = half - ONE_V;
    assign win_lo  = centre - H_V;
    assign win_hi  = centre + H_V;
    assign vote_pt = centre + H_V + ONE_V;
    assign last_pt = presc_x - ONE_V;

    // The first term also guards the wrap of centre/win_lo when half is tiny,
    // so the geometry above is only trusted while cfg_err is low.
    assign cfg_err = (half < HP1_V) || (vote_pt > last_pt);

    // ------------------------------------------------------------------
    // Edge decode
    // ------------------------------------------------------------------
    logic active;
    logic in_window;
    logic at_start;
    logic at_vote;
    logic at_last;

    assign active    = samp_en && !cfg_err;
    assign in_window = (edge_x >= win_lo) && (edge_x <= win_hi);
    assign at_start  = (edge_x == win_lo);
    assign at_vote   = (edge_x == vote_pt);
    assign at_last   = (edge_x == last_pt);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         state;
    logic [2:0]         ones_cnt;
    logic [2:0]         samp_cnt;
    logic [PRESC_W-1:0] last_edge;   // edge index of the most recent sample

    logic new_edge;
    logic room;
    logic take;
    logic short_win;
    logic split_vote;

    // A stalled edge_cnt repeats the same index; only the first occurrence
    // is sampled, and the sample counter caps the total at NUM_SAMPLES.
    assign new_edge   = (edge_cnt != last_edge);
    assign room       = (samp_cnt < N_3);
    assign take       = in_window && new_edge && room;
    assign short_win  = (samp_cnt != N_3);
    assign split_vote = (ones_cnt != 3'd0) && (ones_cnt != N_3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ones_cnt    <= 3'd0;
            samp_cnt    <= 3'd0;
            last_edge   <= '0;
            sampled_bit <= 1'b0;
            bit_valid   <= 1'b0;
            noise_err   <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            if (!active) begin
                // Abort: discard partial samples, keep the last vote visible.
                state    <= S_IDLE;
                ones_cnt <= 3'd0;
                samp_cnt <= 3'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // The first window edge is sampled on entry.
                        if (at_start) begin
                            state     <= S_COLLECT;
                            ones_cnt  <= {2'b00, rx_in};
                            samp_cnt  <= 3'd1;
                            last_edge <= edge_cnt;
                        end
                    end
                    S_COLLECT: begin
                        if (at_vote) begin
                            sampled_bit <= (ones_cnt > H_3);
                            // A window cut short is never trusted as clean.
                            noise_err   <= short_win || split_vote;
                            bit_valid   <= 1'b1;
                            // When the vote point is also the final edge of the
                            // bit there is no HOLD interval: the next bit's
                            // window may start on the very next edge.
                            if (at_last) begin
                                state    <= S_IDLE;
                                ones_cnt <= 3'd0;
                                samp_cnt <= 3'd0;
                            end else begin
                                state <= S_HOLD;
                            end
                        end else if (take) begin
                            ones_cnt  <= ones_cnt + {2'b00, rx_in};
                            samp_cnt  <= samp_cnt + 3'd1;
                            last_edge <= edge_cnt;
                        end
                    end
                    S_HOLD: begin
                        if (at_last) begin
                            state    <= S_IDLE;
                            ones_cnt <= 3'd0;
                            samp_cnt <= 3'd0;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        ones_cnt <= 3'd0;
                        samp_cnt <= 3'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oversample_voter.sv
// Purpose : self-checking bench for oversample_voter (NUM_SAMPLES 3 and 5 instances).
// Latency : expected votes are queued when the vote edge is driven, checked one clock later.
// Backpressure: none; the bench drives edge_cnt as the RX FSM would.
module tb_oversample_voter;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic       en3;
    logic       en5;
    logic [5:0] edge_cnt;
    logic [5:0] prescale;

    logic sb3, bv3, nz3, cf3;
    logic sb5, bv5, nz5, cf5;

    oversample_voter #(.PRESC_W(6), .NUM_SAMPLES(3)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .samp_en     (en3),
        .edge_cnt    (edge_cnt),
        .prescale    (prescale),
        .sampled_bit (sb3),
        .bit_valid   (bv3),
        .noise_err   (nz3),
        .cfg_err     (cf3)
    );

    oversample_voter #(.PRESC_W(6), .NUM_SAMPLES(5)) dut5 (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .samp_en     (en5),
        .edge_cnt    (edge_cnt),
        .prescale    (prescale),
        .sampled_bit (sb5),
        .bit_valid   (bv5),
        .noise_err   (nz5),
        .cfg_err     (cf5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp  = 0;
    int n_fail = 0;
    int vcnt3  = 0;
    int vcnt5  = 0;

    typedef struct {
        logic b;
        logic n;
        int   cyc;
    } exp_t;

    exp_t q3[$];
    exp_t q5[$];

    typedef struct {
        int          n;
        int          p;
        logic [15:0] pat;   // bit i = rx_in at edge i
        logic        eb;
        logic        en;
    } vec_t;

    typedef struct {
        int   p;
        logic c3;
        logic c5;
    } cfg_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard side: every bit_valid pulse must match the oldest queued vote.
    always @(negedge clk) begin
        if (!rst) begin
            if (bv3) begin
                exp_t x;
                vcnt3++;
                if (q3.size() == 0) begin
                    chk("n3 spurious bit_valid", bv3, 0);
                end else begin
                    x = q3.pop_front();
                    chk("n3 sampled_bit", sb3, x.b);
                    chk("n3 noise_err", nz3, x.n);
                    chk("n3 vote latency", cyc, x.cyc);
                end
            end
            if (bv5) begin
                exp_t x;
                vcnt5++;
                if (q5.size() == 0) begin
                    chk("n5 spurious bit_valid", bv5, 0);
                end else begin
                    x = q5.pop_front();
                    chk("n5 sampled_bit", sb5, x.b);
                    chk("n5 noise_err", nz5, x.n);
                    chk("n5 vote latency", cyc, x.cyc);
                end
            end
        end
    end

    task automatic drive(input int e, input logic r, input logic a3, input logic a5);
        @(posedge clk);
        #1;
        edge_cnt = e[5:0];
        rx_in    = r;
        en3      = a3;
        en5      = a5;
    endtask

    task automatic push_exp(input int n, input logic b, input logic nz);
        exp_t x;
        x.b   = b;
        x.n   = nz;
        x.cyc = cyc + 1;
        if (n == 3) q3.push_back(x);
        else        q5.push_back(x);
    endtask

    // Prescale only changes while both enables are low.
    task automatic set_presc(input int p);
        if (prescale != p[5:0]) begin
            @(posedge clk);
            #1;
            en3      = 1'b0;
            en5      = 1'b0;
            prescale = p[5:0];
        end
    endtask

    task automatic run_bit(input int n, input int p, input logic [15:0] pat,
                           input logic eb, input logic en_, input bit push);
        int v;
        set_presc(p);
        v = p / 2 + (n - 1) / 2;   // vote edge: centre + H + 1
        for (int e = 0; e < p; e++) begin
            drive(e, pat[e], n == 3, n == 5);
            if (push && e == v) push_exp(n, eb, en_);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t vt[12];
    cfg_t ct[7];

    initial begin
        int v0;
        logic r;

        vt[0]  = '{3, 8,  16'h001C, 1'b1, 1'b0};  // 1,1,1
        vt[1]  = '{3, 8,  16'h0014, 1'b1, 1'b1};  // 1,0,1
        vt[2]  = '{3, 8,  16'h0010, 1'b0, 1'b1};  // 0,0,1
        vt[3]  = '{3, 8,  16'h0000, 1'b0, 1'b0};  // all zero
        vt[4]  = '{3, 8,  16'h00E3, 1'b0, 1'b0};  // ones only outside window
        vt[5]  = '{3, 8,  16'h0018, 1'b1, 1'b1};  // 0,1,1
        vt[6]  = '{3, 4,  16'h0007, 1'b1, 1'b0};  // window 0..2, vote at 3
        vt[7]  = '{3, 4,  16'h0001, 1'b0, 1'b1};
        vt[8]  = '{3, 7,  16'h000E, 1'b1, 1'b0};  // odd prescale: window 1..3
        vt[9]  = '{5, 16, 16'h0080, 1'b0, 1'b1};  // only edge 7 high
        vt[10] = '{5, 16, 16'h03E0, 1'b1, 1'b0};  // edges 5..9 high
        vt[11] = '{5, 16, 16'h0260, 1'b1, 1'b1};  // 3 of 5 high

        ct[0] = '{2,  1'b1, 1'b1};
        ct[1] = '{3,  1'b1, 1'b1};
        ct[2] = '{4,  1'b0, 1'b1};
        ct[3] = '{5,  1'b0, 1'b1};
        ct[4] = '{6,  1'b0, 1'b0};
        ct[5] = '{8,  1'b0, 1'b0};
        ct[6] = '{16, 1'b0, 1'b0};

        rst      = 1'b1;
        rx_in    = 1'b0;
        en3      = 1'b0;
        en5      = 1'b0;
        edge_cnt = 6'd0;
        prescale = 6'd8;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset sampled_bit", sb3, 0);
        chk("reset bit_valid", bv3, 0);
        chk("reset noise_err", nz3, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset bit_valid", bv3, 0);
        chk("post-reset sampled_bit n5", sb5, 0);

        // cfg_err against prescale.
        for (int i = 0; i < 7; i++) begin
            set_presc(ct[i].p);
            #1;
            chk($sformatf("cfg_err n3 p=%0d", ct[i].p), cf3, ct[i].c3);
            chk($sformatf("cfg_err n5 p=%0d", ct[i].p), cf5, ct[i].c5);
        end

        // Table of single-bit votes.
        for (int i = 0; i < 12; i++)
            run_bit(vt[i].n, vt[i].p, vt[i].pat, vt[i].eb, vt[i].en, 1'b1);

        // prescale too small: 10 bit periods with no vote.
        set_presc(2);
        v0 = vcnt3;
        for (int b = 0; b < 10; b++) begin
            for (int e = 0; e < 2; e++) begin
                r = 1'($urandom_range(0, 1));
                drive(e, r, 1'b1, 1'b0);
            end
        end
        chk("cfg_err p=2 held", cf3, 1);
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 1'b0);
        chk("no vote while cfg_err", vcnt3 - v0, 0);

        // samp_en dropped at edge 3 aborts the bit and keeps the old result.
        run_bit(3, 8, 16'h001C, 1'b1, 1'b0, 1'b1);
        v0 = vcnt3;
        for (int e = 0; e < 8; e++) drive(e, 1'b0, e < 3, 1'b0);
        chk("abort: no bit_valid", vcnt3 - v0, 0);
        chk("abort: sampled_bit held", sb3, 1);
        chk("abort: noise_err held", nz3, 0);
        run_bit(3, 8, 16'h0010, 1'b0, 1'b1, 1'b1);

        // Stalled edge 2: the repeats carry rx=1 but must not be sampled.
        drive(0, 1'b0, 1'b1, 1'b0);
        drive(1, 1'b0, 1'b1, 1'b0);
        drive(2, 1'b0, 1'b1, 1'b0);
        drive(2, 1'b1, 1'b1, 1'b0);
        drive(2, 1'b1, 1'b1, 1'b0);
        drive(3, 1'b0, 1'b1, 1'b0);
        drive(4, 1'b1, 1'b1, 1'b0);
        drive(5, 1'b0, 1'b1, 1'b0);
        push_exp(3, 1'b0, 1'b1);
        drive(6, 1'b0, 1'b1, 1'b0);
        drive(7, 1'b0, 1'b1, 1'b0);

        // Edge 3 skipped: two unanimous samples still vote, flagged noisy.
        drive(0, 1'b0, 1'b1, 1'b0);
        drive(1, 1'b0, 1'b1, 1'b0);
        drive(2, 1'b1, 1'b1, 1'b0);
        drive(4, 1'b1, 1'b1, 1'b0);
        drive(5, 1'b0, 1'b1, 1'b0);
        push_exp(3, 1'b1, 1'b1);
        drive(6, 1'b0, 1'b1, 1'b0);
        drive(7, 1'b0, 1'b1, 1'b0);

        // Reset pulsed mid-window at edge 3.
        for (int e = 0; e < 4; e++) drive(e, 1'b1, 1'b1, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("mid reset sampled_bit", sb3, 0);
        chk("mid reset noise_err", nz3, 0);
        chk("mid reset bit_valid", bv3, 0);
        v0 = vcnt3;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        edge_cnt = 6'd4;
        for (int e = 5; e < 8; e++) drive(e, 1'b1, 1'b1, 1'b0);
        drive(0, 1'b1, 1'b1, 1'b0);
        chk("no vote after reset", vcnt3 - v0, 0);
        run_bit(3, 8, 16'h001C, 1'b1, 1'b0, 1'b1);

        // Drain and confirm every expected vote appeared.
        for (int i = 0; i < 4; i++) drive(0, 1'b0, 1'b0, 1'b0);
        chk("n3 votes outstanding", q3.size(), 0);
        chk("n5 votes outstanding", q5.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/oversample_voter.md
OVERSAMPLE_VOTER -- requirements
Module: oversample_voter

Interface
REQ-001 SHALL have parameter PRESC_W, default 6, meaning width of prescale/edge_cnt.
REQ-002 SHALL have parameter NUM_SAMPLES, default 3, meaning majority-vote sample count; legal values are 1, 3, 5 and 7.
REQ-003 SHALL have port clk  input  1  meaning single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous, active-high.
REQ-005 SHALL have port rx_in  input  1  meaning serial line, already synchronised.
REQ-006 SHALL have port samp_en  input  1  meaning sampling enable from the RX FSM.
REQ-007 SHALL have port edge_cnt  input  PRESC_W  meaning oversample edge index within the current bit, 0..prescale-1.
REQ-008 SHALL have port prescale  input  PRESC_W  meaning oversample ratio, static while samp_en=1.
REQ-009 SHALL have port sampled_bit  output  1  meaning registered vote result.
REQ-010 SHALL have port bit_valid  output  1  meaning one-cycle pulse, sampled_bit updated this cycle.
REQ-011 SHALL have port noise_err  output  1  meaning samples of the last voted bit not unanimous; valid with bit_valid.
REQ-012 SHALL have port cfg_err  output  1  meaning prescale too small for NUM_SAMPLES; combinational.

Function
REQ-013 SHALL define H=(NUM_SAMPLES-1)/2, C=(prescale>>1)-1, window = edge_cnt in [C-H, C+H], vote point V=C+H+1; arithmetic is unsigned at PRESC_W+1 bits.
REQ-014 SHALL assert cfg_err when (prescale>>1) < H+1 or V > prescale-1; while cfg_err=1 no sample, vote or bit_valid occurs.
REQ-015 SHALL implement FSM IDLE, COLLECT, HOLD; reset state IDLE.
REQ-016 IDLE -> COLLECT when samp_en=1, cfg_err=0, edge_cnt=C-H; the sample at that edge is taken in the same cycle.
REQ-017 COLLECT: each cycle with samp_en=1 and edge_cnt in the window, rx_in is taken; a 3-bit ones counter increments on rx_in=1 and a sample counter increments.
REQ-018 COLLECT -> HOLD at edge_cnt=V: sampled_bit <= (ones > H), noise_err <= (ones != 0 and ones != NUM_SAMPLES), bit_valid=1 for that one cycle.
REQ-019 HOLD -> IDLE at edge_cnt=prescale-1; the ones and sample counters clear on that transition.
REQ-020 A window edge repeated on consecutive cycles (edge_cnt not advancing) SHALL be sampled only once; the sample counter gates sampling at NUM_SAMPLES.
REQ-021 samp_en=0 in any state SHALL force IDLE next cycle, clear both counters, suppress bit_valid, and hold sampled_bit and noise_err.
REQ-022 If edge_cnt=V is reached with fewer than NUM_SAMPLES samples, the block SHALL still vote on the samples taken, and noise_err SHALL be forced to 1.
REQ-023 NUM_SAMPLES=1: window is the single edge C, V=C+1, and noise_err is always 0 on valid votes.
REQ-024 Latency: sampled_bit and bit_valid SHALL be registered one clock after the cycle where edge_cnt=V is presented.

Reset
REQ-025 rst=1 SHALL asynchronously set the state to IDLE, clear both counters, and drive sampled_bit=0, bit_valid=0, noise_err=0.
REQ-026 Reset asserted mid-COLLECT SHALL discard partial samples, and no bit_valid SHALL follow reset release until a fresh window.

Verification
REQ-027 N=3, prescale=8, rx_in=1 at edges 2,3,4 -> bit_valid after edge 5, sampled_bit=1, noise_err=0.
REQ-028 N=3, prescale=8, rx_in=1,0,1 at edges 2,3,4 -> sampled_bit=1, noise_err=1; rx_in=0,0,1 -> sampled_bit=0, noise_err=1.
REQ-029 N=5, prescale=16, rx_in=0 at edges 5..9 except edge 7=1 -> vote at edge 10, sampled_bit=0, noise_err=1.
REQ-030 N=3, prescale=2 -> cfg_err=1, no bit_valid over 10 bit periods; prescale=4 -> cfg_err=0, window 0..2, vote at 3.
REQ-031 samp_en dropped at edge 3 of prescale=8 -> no bit_valid; sampled_bit retains its prior value; next bit is voted correctly.
REQ-032 rst pulsed at edge 3 of prescale=8 -> all outputs 0 immediately; no bit_valid until the next edge-2 start.
